// File: rtl/tx_bus_arbiter.sv
// Round-robin frame arbiter for a shared half-duplex UART TX path. It also drives the
// pin output-enable, with a lead guard before the first byte and a hold time after the UART idles.
module tx_bus_arbiter #(
   parameter int NUM_REQ        = 2,
   parameter int DATA_W         = 8,
   parameter int GUARD_CYCLES   = 16,
   parameter int HOLD_CYCLES    = 16,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                        CLK,
   input  logic                        RESET_N,
   input  logic [NUM_REQ-1:0]          req_valid,
   input  logic [NUM_REQ*DATA_W-1:0]   req_data,
   input  logic [NUM_REQ-1:0]          req_last,
   output logic [NUM_REQ-1:0]          req_ready,
   output logic [DATA_W-1:0]           uart_data,
   output logic                        uart_valid,
   input  logic                        uart_ready,
   input  logic                        uart_busy,
   output logic                        tx_enable,
   output logic [NUM_REQ-1:0]          grant,
   output logic                        frame_abort
);

   localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_MAX = (GUARD_CYCLES > HOLD_CYCLES) ? GUARD_CYCLES : HOLD_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int IDL_W   = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [CNT_W-1:0]   GUARD_END = CNT_W'(GUARD_CYCLES - 1);
   localparam logic [CNT_W-1:0]   HOLD_END  = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [IDL_W-1:0]   IDLE_END  = IDL_W'(TIMEOUT_CYCLES - 1);
   localparam logic [IDX_W-1:0]   LAST_RST  = IDX_W'(NUM_REQ - 1);
   localparam logic [NUM_REQ-1:0] ONE_HOT0  = NUM_REQ'(1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LEAD  = 3'd1,
      SEND  = 3'd2,
      DRAIN = 3'd3,
      TAIL  = 3'd4
   } state_t;

   state_t               state_q, state_d;
   logic [NUM_REQ-1:0]   grant_q, grant_d;
   logic [IDX_W-1:0]     gidx_q, gidx_d;
   logic [IDX_W-1:0]     last_q, last_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [IDL_W-1:0]     idle_q, idle_d;
   logic                 tx_en_q, tx_en_d;
   logic                 abort_q, abort_d;

   logic [IDX_W-1:0]     cand_s;
   logic [IDX_W-1:0]     win_idx_s;
   logic                 win_found_s;
   logic                 sel_valid_s;
   logic                 sel_last_s;
   logic [DATA_W-1:0]    sel_data_s;
   logic                 xfer_s;

   // Round-robin search starting one past the last served requester.
   always_comb begin
      win_found_s = 1'b0;
      win_idx_s   = '0;
      cand_s      = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand_s = IDX_W'((int'(last_q) + k) % NUM_REQ);
         if (!win_found_s && req_valid[cand_s]) begin
            win_found_s = 1'b1;
            win_idx_s   = cand_s;
         end else begin
            win_found_s = win_found_s;
         end
      end
   end

   assign sel_valid_s = req_valid[gidx_q];
   assign sel_last_s  = req_last[gidx_q];
   assign sel_data_s  = req_data[int'(gidx_q) * DATA_W +: DATA_W];

   // Combinational SEND datapath from the granted requester to the UART.
   always_comb begin
      uart_valid = 1'b0;
      uart_data  = '0;
      req_ready  = '0;
      if (state_q == SEND) begin
         uart_valid = sel_valid_s;
         uart_data  = sel_data_s;
         req_ready  = grant_q & {NUM_REQ{uart_ready}};
      end else begin
         uart_valid = 1'b0;
      end
   end

   assign xfer_s = uart_valid & uart_ready;

   // Next-state logic for the frame sequencer and its counters.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      gidx_d  = gidx_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      idle_d  = idle_q;
      tx_en_d = tx_en_q;
      abort_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (win_found_s) begin
               state_d = LEAD;
               grant_d = ONE_HOT0 << win_idx_s;
               gidx_d  = win_idx_s;
               tx_en_d = 1'b1;
               cnt_d   = '0;
            end else begin
               tx_en_d = 1'b0;
            end
         end
         LEAD: begin
            if (cnt_q == GUARD_END) begin
               state_d = SEND;
               cnt_d   = '0;
               idle_d  = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         SEND: begin
            if (xfer_s && sel_last_s) begin
               state_d = DRAIN;
               idle_d  = '0;
            end else if (sel_valid_s) begin
               idle_d = '0;
            end else if (idle_q == IDLE_END) begin
               // Granted requester went silent mid-frame: close the frame.
               state_d = DRAIN;
               abort_d = 1'b1;
               idle_d  = '0;
            end else begin
               idle_d = idle_q + IDL_W'(1);
            end
         end
         DRAIN: begin
            if (!uart_busy && uart_ready) begin
               state_d = TAIL;
               cnt_d   = '0;
            end else begin
               state_d = DRAIN;
            end
         end
         TAIL: begin
            if (cnt_q == HOLD_END) begin
               state_d = IDLE;
               grant_d = '0;
               tx_en_d = 1'b0;
               last_d  = gidx_q;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
            tx_en_d = 1'b0;
            cnt_d   = '0;
            idle_d  = '0;
         end
      endcase
   end

   // State and counter registers; reset releases the line immediately.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= IDLE;
         grant_q <= '0;
         gidx_q  <= '0;
         last_q  <= LAST_RST;
         cnt_q   <= '0;
         idle_q  <= '0;
         tx_en_q <= 1'b0;
         abort_q <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         gidx_q  <= gidx_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         idle_q  <= idle_d;
         tx_en_q <= tx_en_d;
         abort_q <= abort_d;
      end
   end

   assign tx_enable   = tx_en_q;
   assign grant       = grant_q;
   assign frame_abort = abort_q;

endmodule

// File: tb/tb_tx_bus_arbiter.sv
// Directed bench for tx_bus_arbiter: single frame, reset, round-robin, backpressure,
// timeout and long-drain scenarios with hand-derived cycle counts.
module tb_tx_bus_arbiter;

   localparam int NR = 2;
   localparam int DW = 8;
   localparam int G  = 16;
   localparam int H  = 16;
   localparam int TO = 32;

   logic            CLK;
   logic            RESET_N;
   logic [NR-1:0]   req_valid;
   logic [NR*DW-1:0] req_data;
   logic [NR-1:0]   req_last;
   logic [NR-1:0]   req_ready;
   logic [DW-1:0]   uart_data;
   logic            uart_valid;
   logic            uart_ready;
   logic            uart_busy;
   logic            tx_enable;
   logic [NR-1:0]   grant;
   logic            frame_abort;

   int n_pass  = 0;
   int n_total = 0;

   tx_bus_arbiter #(
      .NUM_REQ(NR), .DATA_W(DW), .GUARD_CYCLES(G), .HOLD_CYCLES(H), .TIMEOUT_CYCLES(TO)
   ) dut (
      .CLK(CLK), .RESET_N(RESET_N),
      .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
      .uart_data(uart_data), .uart_valid(uart_valid), .uart_ready(uart_ready), .uart_busy(uart_busy),
      .tx_enable(tx_enable), .grant(grant), .frame_abort(frame_abort)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge CLK);
      #2;
   endtask

   task automatic wait_tx_low(output int n);
      n = 0;
      while (tx_enable && n < 300) begin
         step();
         n++;
      end
   endtask

   int            n;
   int            ngr;
   int            k;
   logic [NR-1:0] acc_rdy;
   logic          acc_bit;
   logic          multi;
   logic          gap_bad;
   logic          xfer;
   logic [NR-1:0] prev_grant;
   logic          prev_tx;
   logic [NR-1:0] seq [4];
   logic [7:0]    bp_bytes [4];
   logic [7:0]    got [$];

   initial begin
      bp_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
      RESET_N    = 1'b1;
      req_valid  = 2'b00;
      req_data   = 16'h0000;
      req_last   = 2'b00;
      uart_ready = 1'b1;
      uart_busy  = 1'b0;
      #1 RESET_N = 1'b0;
      #20;
      chk("rst_tx_enable", tx_enable, 0);
      chk("rst_grant", grant, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_uart_valid", uart_valid, 0);
      chk("rst_uart_data", uart_data, 0);
      chk("rst_frame_abort", frame_abort, 0);
      #1 RESET_N = 1'b1;
      step();

      // Single frame from req0: A5, 5A, FF(last)
      req_valid = 2'b01;
      req_data  = 16'h00A5;
      req_last  = 2'b00;
      #1 chk("sf_tx_before", tx_enable, 0);
      step();
      chk("sf_tx_rise", tx_enable, 1);
      chk("sf_grant", grant, 2'b01);
      chk("sf_ready_c1", req_ready, 0);
      acc_rdy = 2'b00;
      repeat (15) begin
         step();
         acc_rdy = acc_rdy | req_ready;
      end
      chk("sf_lead_no_ready", acc_rdy, 0);
      step();
      chk("sf_first_ready_c17", req_ready, 2'b01);
      chk("sf_byte0", uart_data, 8'hA5);
      chk("sf_valid0", uart_valid, 1);
      step();
      req_data  = 16'h005A;
      uart_busy = 1'b1;
      #1 chk("sf_byte1", uart_data, 8'h5A);
      step();
      req_data = 16'h00FF;
      req_last = 2'b01;
      #1 chk("sf_byte2", uart_data, 8'hFF);
      chk("sf_valid2", uart_valid, 1);
      step();
      req_valid = 2'b00;
      req_last  = 2'b00;
      #1 chk("sf_drain_valid", uart_valid, 0);
      chk("sf_drain_tx", tx_enable, 1);
      repeat (3) step();
      chk("sf_drain_held", tx_enable, 1);
      uart_busy = 1'b0;
      wait_tx_low(n);
      chk("sf_tail_len", n, 17);
      chk("sf_idle_grant", grant, 0);

      // Reset in SEND: outputs drop immediately, arbitration restarts at req0
      req_valid = 2'b01;
      req_data  = 16'h0033;
      step();
      repeat (16) step();
      #1 chk("rm_in_send", req_ready, 2'b01);
      RESET_N = 1'b0;
      #1;
      chk("rm_tx", tx_enable, 0);
      chk("rm_grant", grant, 0);
      chk("rm_ready", req_ready, 0);
      chk("rm_valid", uart_valid, 0);
      req_valid = 2'b11;
      req_data  = 16'h2110;
      req_last  = 2'b11;
      #1 RESET_N = 1'b1;

      // Round-robin with both requesters continuously valid, 1-byte frames
      ngr        = 0;
      multi      = 1'b0;
      gap_bad    = 1'b0;
      prev_grant = grant;
      prev_tx    = tx_enable;
      for (int c = 0; c < 400 && !(ngr == 4 && grant == 2'b00); c++) begin
         step();
         if ($countones(grant) > 1) multi = 1'b1;
         if (grant != 2'b00 && prev_grant == 2'b00 && ngr < 4) begin
            seq[ngr] = grant;
            ngr++;
            if (prev_tx) gap_bad = 1'b1;
         end
         if (uart_valid && uart_ready)
            chk("rr_data", uart_data, grant[0] ? 8'h10 : 8'h21);
         prev_grant = grant;
         prev_tx    = tx_enable;
      end
      req_valid = 2'b00;
      req_last  = 2'b00;
      chk("rr_count", ngr, 4);
      for (int i = 0; i < 4; i++)
         chk("rr_order", seq[i], (i % 2 == 0) ? 2'b01 : 2'b10);
      chk("rr_onehot", multi, 0);
      chk("rr_gap", gap_bad, 0);

      // Backpressure: uart_ready toggles during a 4-byte frame from req0
      k       = 0;
      acc_bit = 1'b0;
      for (int c = 0; c < 70; c++) begin
         req_valid  = (k < 4) ? 2'b01 : 2'b00;
         req_data   = {8'h00, bp_bytes[(k < 4) ? k : 0]};
         req_last   = {1'b0, (k == 3)};
         uart_ready = (c % 2 == 1);
         #1;
         if (req_ready[1]) acc_bit = 1'b1;
         xfer = uart_valid && uart_ready;
         if (xfer) got.push_back(uart_data);
         step();
         if (xfer) k++;
      end
      uart_ready = 1'b1;
      req_valid  = 2'b00;
      req_last   = 2'b00;
      chk("bp_ready1_zero", acc_bit, 0);
      chk("bp_xfer_count", got.size(), 4);
      for (int i = 0; i < 4; i++)
         if (i < got.size()) chk("bp_byte", got[i], bp_bytes[i]);
      chk("bp_back_idle", tx_enable, 0);

      // Timeout: req1 sends one non-last byte then goes silent
      req_valid = 2'b10;
      req_data  = 16'h7700;
      req_last  = 2'b00;
      step();
      chk("to_grant", grant, 2'b10);
      repeat (16) step();
      #1 chk("to_ready", req_ready, 2'b10);
      step();
      req_valid = 2'b00;
      n = 0;
      while (!frame_abort && n < 60) begin
         step();
         n++;
      end
      chk("to_abort_delay", n, 32);
      chk("to_abort_tx", tx_enable, 1);
      step();
      chk("to_abort_pulse", frame_abort, 0);
      wait_tx_low(n);
      chk("to_tail_len", n, 16);
      req_valid = 2'b11;
      req_data  = 16'h4499;
      req_last  = 2'b01;
      step();
      chk("to_next_grant", grant, 2'b01);

      // Long drain: busy stays high for 200 cycles after the last byte
      repeat (16) step();
      #1 chk("dh_ready_only0", req_ready, 2'b01);
      chk("dh_byte", uart_data, 8'h99);
      uart_busy = 1'b1;
      step();
      req_valid = 2'b00;
      req_last  = 2'b00;
      acc_bit   = 1'b0;
      repeat (200) begin
         step();
         if (!tx_enable) acc_bit = 1'b1;
      end
      chk("dh_tx_held", acc_bit, 0);
      chk("dh_grant_held", grant, 2'b01);
      uart_busy = 1'b0;
      wait_tx_low(n);
      chk("dh_tail_len", n, 17);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/tx_bus_arbiter.md
# tx_bus_arbiter

Frame-level arbiter and line-direction controller for a shared half-duplex UART transmit path on the motorboard FPGA. It sits between `NUM_REQ` byte-stream requesters (e.g. the `coms` status and telemetry channels) and one UART transmit byte engine. Requesters are served round-robin, one whole frame per grant. The block drives the pin output-enable (`tx_enable`) with programmable lead and tail guard times, so the open line is only driven while a frame is in flight.

## Interface
- `NUM_REQ`, 2: number of requesters (2..8)
- `DATA_W`, 8: byte width
- `GUARD_CYCLES`, 16: cycles `tx_enable` is high before the first byte is offered (>=1)
- `HOLD_CYCLES`, 16: cycles `tx_enable` stays high after the UART goes idle (>=1)
- `TIMEOUT_CYCLES`, 1024: consecutive cycles of no `req_valid` from the granted requester mid-frame before forced frame end (>=2)

Ports:
- `CLK`  in  1  system clock, 16 MHz
- `RESET_N`  in  1  asynchronous, active-low reset
- `req_valid`  in  NUM_REQ  per-requester byte valid
- `req_data`  in  NUM_REQ*DATA_W  packed bytes; requester i at [i*DATA_W +: DATA_W]
- `req_last`  in  NUM_REQ  marks the final byte of a frame
- `req_ready`  out  NUM_REQ  per-requester byte accepted
- `uart_data`  out  DATA_W  byte to the UART transmitter
- `uart_valid`  out  1  byte offered to the UART
- `uart_ready`  in  1  UART can accept a byte
- `uart_busy`  in  1  UART shift register active
- `tx_enable`  out  1  pin output-enable for the TX line
- `grant`  out  NUM_REQ  one-hot current owner; zero when idle
- `frame_abort`  out  1  one-cycle pulse on timeout

## Operation
- States: IDLE, LEAD, SEND, DRAIN, TAIL.
- **IDLE**
  - `tx_enable`=0, `grant`=0, all `req_ready`=0.
  - If any `req_valid` is high, select the winner round-robin: search starts at (last_served+1) mod NUM_REQ.
  - Register the winner into `grant` and go to LEAD.
  - last_served resets to NUM_REQ-1, so requester 0 wins first.
- **LEAD**
  - `tx_enable`=1, `grant` held.
  - Counter runs for GUARD_CYCLES cycles, then go to SEND.
- **SEND**
  - `uart_valid` = `req_valid[g]` and `uart_data` = granted slice, both combinational.
  - `req_ready[g]` = `uart_ready`; all other `req_ready` bits stay 0.
  - A transfer occurs when valid and ready are both high.
  - Transfer with `req_last[g]`=1: go to DRAIN.
  - Idle counter increments on each cycle with `req_valid[g]`=0 and clears on any cycle it is 1.
  - Idle counter reaching TIMEOUT_CYCLES: pulse `frame_abort`, go to DRAIN.
- **DRAIN**
  - `uart_valid`=0, `req_ready`=0, `tx_enable`=1.
  - Exit to TAIL on the first sampled cycle with `uart_busy`=0 and `uart_ready`=1.
- **TAIL**
  - `tx_enable`=1 for HOLD_CYCLES cycles.
  - Then go to IDLE: `grant` clears and last_served is set to g.
- **Non-preemption:** requests from other requesters during a frame are ignored until IDLE. A requester that drops `req_valid` mid-frame keeps the grant until `req_last` or timeout.
- **Reset:** asserting `RESET_N` low in any state immediately forces IDLE and clears all counters and last_served. The bytes in the UART are abandoned and the line is released at once.

## Timing
- Reset values: `tx_enable`=0, `grant`=0, `req_ready`=0, `uart_valid`=0, `uart_data`=0, `frame_abort`=0.
- Request accepted in IDLE at edge 0: `grant` and `tx_enable` high from cycle 1.
- First possible `req_ready`: cycle 1+GUARD_CYCLES.
- SEND adds zero latency; with `uart_ready` held high, back-to-back bytes go one per cycle.
- DRAIN exit sampled at edge t: TAIL covers cycles t+1 .. t+HOLD_CYCLES, and `tx_enable` falls at cycle t+1+HOLD_CYCLES.
- Frame spacing: at least one IDLE cycle between frames, so `tx_enable` is low for at least 1 cycle.
- `frame_abort` is high during the cycle of entry to DRAIN.
- All outputs except the combinational SEND datapath (`uart_valid`, `uart_data`, `req_ready`) are registered.

## Test plan
- **Single frame:** req0 sends 3 bytes 0xA5, 0x5A, 0xFF (last on 0xFF), GUARD=HOLD=16.
  - `tx_enable` rises at cycle 1.
  - First `req_ready[0]` at cycle 17.
  - `uart_data` sequence is exact.
  - `tx_enable` falls 17 cycles after `uart_busy` drops.
- **Round-robin:** req0 and req1 both valid continuously, 1-byte frames.
  - Grants alternate 0,1,0,1.
  - Never two grants high at once.
  - `tx_enable` low for at least 1 cycle between frames.
- **Backpressure:** `uart_ready` toggles every other cycle during a 4-byte frame.
  - Exactly 4 transfers, no byte duplicated or lost.
  - `req_ready[1]` stays 0 throughout.
- **Timeout:** req1 sends 1 non-last byte, then drops valid; TIMEOUT=32.
  - `frame_abort` pulses exactly 32 cycles after the last valid.
  - Normal TAIL follows.
  - Next grant goes to req0.
- **Reset mid-frame:** assert `RESET_N`=0 in SEND.
  - Same cycle (asynchronous): `tx_enable`, `grant`, `req_ready` all 0.
  - After release, req0 wins first arbitration.
- **DRAIN hold:** `uart_busy` stays high for 200 cycles after the last byte.
  - `tx_enable` remains 1 for the whole period.
  - `tx_enable` falls exactly HOLD+1 cycles after busy clears.
